uart_tx_arbiter: RTL

- Shares one uart_tx transmitter between NUM_REQ independent byte-stream requesters, for example a register-readback FSM, a debug printer and a status reporter.
- Arbitration is round-robin at packet granularity. Once granted, a requester keeps the transmitter until it sends a byte flagged last, so messages never interleave on uart_txd.
- Sits between the requesters and uart_tx's tx_enable/tx_data/tx_busy interface, and sequences each byte through uart_tx's busy handshake.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose : shared constants for the UART transmit-side arbitration slice.
// Latency : n/a (constants only).
// Backpressure: n/a (constants only).
//
// Contents: arbiter FSM state encodings (2 bits) and the byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  // Legacy-compatible state encoding for the TX arbiter FSM.
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_SEND = 2'd1;
  localparam logic [1:0] ARB_WAIT = 2'd2;
  localparam logic [1:0] ARB_NEXT = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Purpose : combinational round-robin picker, first set request after ptr.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the winner is consumed.
//
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index of the last winner; scanning starts at ptr+1 (wraps)
//   win     - one-hot winner, zero when no request is set
//   win_idx - binary index of the winner (zero when none)
//   any     - at least one request is set
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  int unsigned pos;

  // Scan ptr+1 .. ptr+N modulo N; the first hit wins, so the previous winner
  // (at ptr itself) is visited last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    pos     = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        win[pos] = 1'b1;
        win_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose : shares one uart_tx between NUM_REQ byte streams, round-robin per packet.
// Latency : byte accepted at edge k drives tx_enable from cycle k+1.
// Backpressure: one req_ready bit at most; held low while uart_tx is busy.
//
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   req_valid/data/last    - per-requester byte stream (data: 8 bits per requester)
//   req_ready              - combinational accept, at most one bit high
//   grant                  - one-hot current lock owner, zero when unlocked
//   tx_busy/enable/data    - handshake with uart_tx
//   timeout_err            - one-cycle pulse when a stalled packet is abandoned
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      tx_busy,
  output logic                      tx_enable,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]           state;
  logic [IW-1:0]        ptr;
  logic                 hold_last;
  logic [TIMEOUT_W-1:0] stall_cnt;
  logic [TIMEOUT_W-1:0] stall_nxt;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic [IW-1:0]        sel_idx;
  logic [BYTE_W-1:0]    sel_byte;
  logic                 sel_last;
  logic                 xfer;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .win     (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // While locked, ptr already equals the granted index, so it doubles as
  // the owner's select in NEXT.
  assign sel_idx   = (state == ARB_IDLE) ? pick_idx : ptr;
  assign sel_byte  = req_data[BYTE_W*sel_idx +: BYTE_W];
  assign sel_last  = req_last[sel_idx];
  assign stall_nxt = stall_cnt + 1'b1;
  assign tx_enable = (state == ARB_SEND);

  // Gated by resetn so ready drops immediately on reset even though the
  // picker is purely combinational from req_valid.
  always_comb begin
    req_ready = '0;
    if (resetn) begin
      case (state)
        ARB_IDLE: req_ready = pick_oh;
        ARB_NEXT: req_ready = grant;
        default:  req_ready = '0;
      endcase
    end
  end

  always_comb begin
    xfer = 1'b0;
    case (state)
      ARB_IDLE: xfer = pick_any;
      ARB_NEXT: xfer = req_valid[ptr];
      default:  xfer = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      tx_data     <= '0;
      hold_last   <= 1'b0;
      ptr         <= IW'(NUM_REQ - 1);
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (xfer) begin
            tx_data   <= sel_byte;
            hold_last <= sel_last;
            grant     <= pick_oh;
            ptr       <= pick_idx;
            state     <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (tx_busy) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (!tx_busy) begin
            if (hold_last) begin
              grant <= '0;
              state <= ARB_IDLE;
            end else begin
              stall_cnt <= '0;
              state     <= ARB_NEXT;
            end
          end
        end
        ARB_NEXT: begin
          if (xfer) begin
            tx_data   <= sel_byte;
            hold_last <= sel_last;
            state     <= ARB_SEND;
          end else begin
            stall_cnt <= stall_nxt;
            // Abandon the packet; ptr stays on the owner so it ranks last.
            if (&stall_nxt) begin
              timeout_err <= 1'b1;
              grant       <= '0;
              state       <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
